clock_divider_multi: RTL

//  Parametrised successor to the single-channel clock divider.

---
 rtl/clock_divider_multi.sv | 96 +++++++++
 1 files changed

// File: rtl/clock_divider_multi.sv
// clock_divider_multi: NCH independent divided-clock / strobe generators.
// Each channel has a run-time divisor and mode. Changes are taken into shadow
// registers only at a period boundary, so an output never glitches mid-period.
// Optional feature macro: CLKDIV_SYNC_EN adds a `sync` input that phase-aligns
// all channels.
module clock_divider_multi #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned DIV_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
`ifdef CLKDIV_SYNC_EN
  input  logic               sync,
`endif
  input  logic [NCH*DIV_W-1:0] div,
  input  logic [NCH-1:0]     mode,
  output logic [NCH-1:0]     div_clk,
  output logic [NCH-1:0]     tick
);

  logic [DIV_W-1:0] cnt    [NCH];
  logic [DIV_W-1:0] sdiv   [NCH];
  logic [DIV_W-1:0] div_ch [NCH];
  logic [NCH-1:0]   smode;
  logic [NCH-1:0]   term;
  logic             sync_req;

`ifdef CLKDIV_SYNC_EN
  assign sync_req = sync;
`else
  assign sync_req = 1'b0;
`endif

  // Split the divisor bus and evaluate each channel's terminal condition
  // from registered state only.
  always_comb begin
    div_ch = '{default: '0};
    term   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      div_ch[i] = div[i*DIV_W +: DIV_W];
      term[i]   = (sdiv[i] == '0) || (cnt[i] == sdiv[i] - DIV_W'(1));
    end
  end

  // Per-channel counter, shadow reload and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt[i]  <= '0;
        sdiv[i] <= '0;
      end
      smode   <= '0;
      div_clk <= '0;
      tick    <= '0;
    end else if (en) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (sync_req) begin
          cnt[i]     <= '0;
          div_clk[i] <= 1'b0;
          tick[i]    <= 1'b0;
          sdiv[i]    <= div_ch[i];
          smode[i]   <= mode[i];
        end else if (!term[i]) begin
          cnt[i]  <= cnt[i] + DIV_W'(1);
          tick[i] <= 1'b0;
          if (smode[i]) begin
            div_clk[i] <= 1'b0;
          end
        end else if (sdiv[i] == '0) begin
          // Idle channel keeps sampling inputs so a new divisor starts promptly.
          cnt[i]     <= '0;
          div_clk[i] <= 1'b0;
          tick[i]    <= 1'b0;
          sdiv[i]    <= div_ch[i];
          smode[i]   <= mode[i];
        end else begin
          cnt[i]   <= '0;
          tick[i]  <= 1'b1;
          sdiv[i]  <= div_ch[i];
          smode[i] <= mode[i];
          if (mode[i] != smode[i]) begin
            div_clk[i] <= 1'b0;
          end else if (!smode[i]) begin
            div_clk[i] <= ~div_clk[i];
          end else begin
            div_clk[i] <= 1'b1;
          end
        end
      end
    end else begin
      tick <= '0;
    end
  end

endmodule
